// File: rtl/tour_pkg.sv
// Shared constants and FSM state type for knight's-tour playback (tour_cmd).
// Command word is {opcode[3:0], heading[7:0], squares[3:0]}.
package tour_pkg;

    localparam logic [7:0] HEAD_N = 8'h00;
    localparam logic [7:0] HEAD_W = 8'h3F;
    localparam logic [7:0] HEAD_S = 8'h7F;
    localparam logic [7:0] HEAD_E = 8'hBF;

    localparam logic [3:0] OP_MOVE         = 4'h2;
    localparam logic [3:0] OP_MOVE_FANFARE = 4'h3;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_POS  = 8'h5A;
    localparam logic [7:0] RESP_ERR  = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        HOLD_V,
        HORZ,
        HOLD_H
    } state_t;

endpackage

// File: rtl/move_decode.sv
// Combinational decode of a one-hot knight move into its vertical and horizontal
// motion commands; the lowest set bit wins if more than one bit is set.
module move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd
);

    logic signed [2:0] dx;
    logic signed [2:0] dy;
    logic signed [2:0] dx_abs;
    logic signed [2:0] dy_abs;

    always_comb begin
        dx = 3'sd0;
        dy = 3'sd0;
        if      (move[0]) begin dx = -3'sd1; dy =  3'sd2; end
        else if (move[1]) begin dx =  3'sd1; dy =  3'sd2; end
        else if (move[2]) begin dx = -3'sd2; dy =  3'sd1; end
        else if (move[3]) begin dx = -3'sd2; dy = -3'sd1; end
        else if (move[4]) begin dx = -3'sd1; dy = -3'sd2; end
        else if (move[5]) begin dx =  3'sd1; dy = -3'sd2; end
        else if (move[6]) begin dx =  3'sd2; dy = -3'sd1; end
        else if (move[7]) begin dx =  3'sd2; dy =  3'sd1; end
    end

    assign dx_abs = (dx < 3'sd0) ? -dx : dx;
    assign dy_abs = (dy < 3'sd0) ? -dy : dy;

    assign vert_cmd = {OP_MOVE, (dy > 3'sd0) ? HEAD_N : HEAD_S, 1'b0, $unsigned(dy_abs)};
    assign horz_cmd = {OP_MOVE_FANFARE, (dx > 3'sd0) ? HEAD_E : HEAD_W, 1'b0, $unsigned(dx_abs)};

endmodule

// File: rtl/tour_cmd.sv
// Knight's-tour playback: turns each solver move into a vertical then horizontal command,
// else passes UART commands through. Define TOUR_CMD_ILLEGAL_CHK_EN to abort on non-one-hot moves (adds err).
module tour_cmd
    import tour_pkg::*;
#(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic             clr_cmd_rdy_UART,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [7:0]       resp,
    output logic             tour_busy
`ifdef TOUR_CMD_ILLEGAL_CHK_EN
    ,
    output logic             err
`endif
);

    state_t      state;
    logic        tour_rdy;
    logic        last_move;
    logic        abort_p;
    logic [15:0] vert_cmd;
    logic [15:0] horz_cmd;

    move_decode u_move_decode (
        .move     (move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd)
    );

    assign last_move = (mv_indx == IDX_W'(NUM_MOVES - 1));

`ifdef TOUR_CMD_ILLEGAL_CHK_EN
    logic move_ok;
    assign move_ok = (move != 8'd0) && ((move & (move - 8'd1)) == 8'd0);
`else
    assign abort_p = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mv_indx  <= '0;
            tour_rdy <= 1'b0;
`ifdef TOUR_CMD_ILLEGAL_CHK_EN
            abort_p  <= 1'b0;
            err      <= 1'b0;
`endif
        end else begin
`ifdef TOUR_CMD_ILLEGAL_CHK_EN
            abort_p <= 1'b0;
`endif
            case (state)
                IDLE: if (start_tour) begin
                    state    <= VERT;
                    mv_indx  <= '0;
                    tour_rdy <= 1'b1;
`ifdef TOUR_CMD_ILLEGAL_CHK_EN
                    err      <= 1'b0;
`endif
                end
                VERT:
`ifdef TOUR_CMD_ILLEGAL_CHK_EN
                if (!move_ok) begin
                    state    <= IDLE;
                    tour_rdy <= 1'b0;
                    abort_p  <= 1'b1;
                    err      <= 1'b1;
                end else
`endif
                if (clr_cmd_rdy) begin
                    state    <= HOLD_V;
                    tour_rdy <= 1'b0;
                end
                HOLD_V: if (send_resp) begin
                    state    <= HORZ;
                    tour_rdy <= 1'b1;
                end
                HORZ: if (clr_cmd_rdy) begin
                    state    <= HOLD_H;
                    tour_rdy <= 1'b0;
                end
                HOLD_H: if (send_resp) begin
                    if (last_move) begin
                        state <= IDLE;
                    end else begin
                        state    <= VERT;
                        mv_indx  <= mv_indx + IDX_W'(1);
                        tour_rdy <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tour_rdy <= 1'b0;
                end
            endcase
        end
    end

    assign tour_busy        = (state != IDLE);
    assign cmd_rdy          = tour_busy ? tour_rdy : cmd_rdy_UART;
    assign clr_cmd_rdy_UART = tour_busy ? 1'b0 : clr_cmd_rdy;

    always_comb begin
        cmd = cmd_UART;
        if (state == VERT || state == HOLD_V)
            cmd = vert_cmd;
        else if (state == HORZ || state == HOLD_H)
            cmd = horz_cmd;
    end

    // The final HOLD_H acknowledge already reports done, since it returns to IDLE.
    always_comb begin
        resp = RESP_POS;
        if (state == IDLE)
            resp = abort_p ? RESP_ERR : RESP_DONE;
        else if (state == HOLD_H && last_move)
            resp = RESP_DONE;
    end

endmodule

// File: doc/tour_cmd.md
Name: tour_cmd

Overview:
Reader/consumer of the solved knight's tour held in the tour solver's move memory. After the solver asserts done, it walks mv_indx 0..NUM_MOVES-1 and reads each one-hot move. Each move becomes two motion commands (vertical leg, then horizontal leg) for the command processor. When not touring, the UART command path passes straight through to the command processor.

Parameters:
NUM_MOVES, 24, moves in tour (5x5 board, 25 squares)
IDX_W, 5, width of mv_indx

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_tour  in  1  one-cycle pulse; solver done, begin playback
move  in  8  one-hot move at mv_indx (from solver)
mv_indx  out  IDX_W  index of move being read
cmd_UART  in  16  command from UART wrapper
cmd_rdy_UART  in  1  UART command valid
clr_cmd_rdy_UART  out  1  consume pulse back to UART wrapper
cmd  out  16  command to command processor
cmd_rdy  out  1  command valid to command processor
clr_cmd_rdy  in  1  command processor consumed cmd
send_resp  in  1  command processor finished executing a command
resp  out  8  response byte to UART transmit
tour_busy  out  1  high while playback active

Behaviour:
- Move bits: 0:(-1,+2) 1:(+1,+2) 2:(-2,+1) 3:(-2,-1) 4:(-1,-2) 5:(+1,-2) 6:(+2,-1) 7:(+2,+1), as (dx,dy).
- cmd format: [15:12] opcode, [11:4] heading, [3:0] squares. Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- Vertical leg: opcode 4'h2, heading N if dy>0 else S, squares=|dy|.
- Horizontal leg: opcode 4'h3 (move with fanfare), heading E if dx>0 else W, squares=|dx|.
- FSM states: IDLE, VERT, HOLD_V, HORZ, HOLD_H.
- IDLE: mux selects UART. cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy. resp=8'hA5. start_tour -> VERT, mv_indx<=0.
- VERT: cmd=vertical leg, cmd_rdy=1. clr_cmd_rdy -> HOLD_V. cmd_rdy drops the next cycle.
- HOLD_V: cmd_rdy=0. send_resp -> HORZ. resp=8'h5A (non-final acknowledge).
- HORZ: horizontal leg presented, cmd_rdy=1. clr_cmd_rdy -> HOLD_H.
- HOLD_H on send_resp:
  - if mv_indx==NUM_MOVES-1: go to IDLE, resp=8'hA5 for that response.
  - else: mv_indx increments, go to VERT, resp=8'h5A.
- move is sampled combinationally in VERT/HORZ. mv_indx is stable from entering VERT through leaving HOLD_H.
- Tour mode: clr_cmd_rdy_UART=0; UART commands are ignored, not queued.
- start_tour outside IDLE is ignored.
- clr_cmd_rdy and send_resp in the same cycle: clr_cmd_rdy is honoured; send_resp is ignored outside HOLD states.
- tour_busy=1 in every state except IDLE.
- Reset, including mid-tour: state=IDLE, mv_indx=0, tour_busy=0, and all tour-side registered outputs cleared. cmd_rdy then follows cmd_rdy_UART combinationally.

Optional Feature:
- Macro: TOUR_CMD_ILLEGAL_CHK_EN.
- Enabled:
  - In VERT, a move that is not exactly one-hot (zero or more than one bit set) aborts playback.
  - On abort: return to IDLE, drive resp=8'hEE for one send_resp-equivalent cycle, and set sticky err output bit (extra 1-bit port err, cleared only by reset or start_tour).
- Disabled: no check, no err port; decode assumes one-hot with lowest set bit priority.

Decomposition:
- Shared package tour_pkg:
  - heading constants HEAD_N/W/S/E
  - opcode constants OP_MOVE, OP_MOVE_FANFARE
  - resp constants RESP_DONE=8'hA5, RESP_POS=8'h5A
  - FSM state enum
- Sub-module move_decode: pure combinational, move[7:0] -> {vert_cmd[15:0], horz_cmd[15:0]}. Reused by testbench scoreboard.

Test Plan:
1. Idle passthrough: cmd_UART=16'h2003, cmd_rdy_UART=1, clr_cmd_rdy pulse -> cmd=16'h2003, cmd_rdy=1, clr_cmd_rdy_UART pulses same cycle, tour_busy=0.
2. Single move decode: move=8'h02, start_tour:
   - first cmd=16'h2002;
   - after clr_cmd_rdy+send_resp, cmd=16'h3BF1;
   - mv_indx stays 0 until second send_resp.
3. Full tour: model memory returns 8'h80 for all 24 moves with auto clr/resp -> 48 cmds, 47 resp=8'h5A, final resp=8'hA5, mv_indx sequence 0..23, then IDLE.
4. Reset mid-tour at mv_indx=7 in HOLD_V -> next cycle tour_busy=0, mv_indx=0, mux back to UART; subsequent start_tour restarts at 0.
5. Backpressure: hold clr_cmd_rdy low 50 cycles in VERT -> cmd and cmd_rdy stable, no mv_indx change; spurious send_resp ignored.
6. With TOUR_CMD_ILLEGAL_CHK_EN: move=8'h03 at mv_indx=4 -> abort to IDLE, resp=8'hEE, err=1 until next start_tour.
